noc_input_buffer: RTL and testbench
===================================

Name: noc_input_buffer

Overview:
- Per-port input FIFO that sits directly upstream of the router's route-computation stage.
- Accepts 32-bit flits from a neighbour link or the PE with a valid/ready handshake and buffers them.
- Presents one flit per cycle to the route stage as a registered enable + flit pair, and holds off while the switch stage signals stall.
- Tracks packet framing (header → body → tail) and counts framing errors.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream flit valid.
- in_flit  in  32  upstream flit; [31:30] type: 10 header, 11 handshake, 00 body, 01 tail.
- in_ready  out  1  buffer can accept a flit this cycle.
- stall  in  1  downstream switch busy; no pop while high.
- out_enable  out  1  one-cycle strobe: out_flit is valid for the route stage.
- out_flit  out  32  flit to the route stage.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.
- frame_err_cnt  out  8  saturating count of framing errors.

Behaviour:
- Reset (async, immediate) sets all outputs and state to 0: pointers 0, count 0, out_enable 0, out_flit 0, frame_err_cnt 0, FSM to IDLE. in_ready = 1 once rst deasserts.
- in_ready is combinational: (count != DEPTH). It depends only on registered count, never on same-cycle pop.
- Push happens when in_valid & in_ready at a clk edge. The flit is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Pop happens when count != 0 & !stall at a clk edge:
  - out_flit <= mem[rd_ptr], out_enable <= 1, rd_ptr wraps modulo DEPTH.
  - Otherwise out_enable <= 0 and out_flit holds its last value.
- Push and pop in the same cycle leave count unchanged. Push only: +1. Pop only: -1.
- Latency: a flit pushed at edge N with an empty FIFO and no stall gives out_enable high in the cycle after edge N+1 (2 cycles).
- Full: in_ready = 0. Any in_valid is ignored and not counted, even if a pop occurs the same cycle.
- Empty: out_enable = 0 regardless of stall.
- stall asserted mid-stream: popping freezes on the next edge. Entries and order are preserved, and no flit is duplicated or lost.
- Framing FSM, evaluated on each accepted push:
  - IDLE: header (10) → IN_PKT. Handshake (11) is single-flit and stays IDLE. Body or tail → frame_err_cnt+1, stay IDLE.
  - IN_PKT: body → stay. Tail → IDLE. Header or handshake → frame_err_cnt+1, go to IN_PKT for a header, IDLE for a handshake.
  - Erroneous flits are still stored and forwarded; the buffer never drops data.
  - frame_err_cnt saturates at 255.
- Reset asserted mid-packet or mid-stall discards all contents immediately and returns the FSM to IDLE.

Optional Feature:
- NOC_IBUF_BYPASS_EN.
- Defined: when count == 0, !stall and a push occurs, the flit goes straight to out_flit with out_enable <= 1 on that same edge and is not written to memory. Latency becomes 1 cycle, and count stays 0.
- Undefined: no bypass; every flit passes through memory with the 2-cycle minimum latency.
- Framing FSM and error counting are identical in both builds.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W = 32.
  - Flit type constants FT_HEADER = 2'b10, FT_HSHAKE = 2'b11, FT_BODY = 2'b00, FT_TAIL = 2'b01.
  - Type field range [31:30].
  - Gate codes (north 000, east 001, south 010, west 011, PE 100), shared with the route stage.
- One sub-module, noc_fifo_mem: a DEPTH x 32 register array with write port and registered read. The framing FSM and the handshake stay in noc_input_buffer.

Test Plan:
- Reset then push header 0x8140_0000, body 0x0000_0001, tail 0x4000_0002 with stall = 0 → out_enable pulses 3 consecutive cycles, first 2 cycles after the first push, flits in order, frame_err_cnt = 0.
- Hold stall = 1 and push 5 flits with DEPTH = 4 → in_ready drops after the 4th, 5th not accepted, count = 4. Release stall → exactly 4 flits out in order, count returns to 0.
- Continuous push and pop at full rate for 20 flits (pointer wrap) → count stays at 1, output sequence equals input sequence.
- Push body 0x0000_0005 in IDLE, then header, then header → frame_err_cnt = 2, all 3 flits forwarded.
- Assert rst for one cycle with 3 flits queued → out_enable 0 immediately, count 0, following push appears 2 cycles later.
- With NOC_IBUF_BYPASS_EN, single push to an empty unstalled buffer → out_enable high the cycle right after the push edge, count stays 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit type encoding, gate codes and
// the input-buffer framing states. Used by the input buffer and route stage.
package noc_pkg;

  localparam int FLIT_W  = 32;
  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;

  // Flit type field encoding, carried in bits [TYPE_HI:TYPE_LO]
  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEADER = 2'b10,
    FT_HSHAKE = 2'b11
  } flit_type_t;

  // Output gate codes, shared with the route-computation stage
  typedef enum logic [2:0] {
    GATE_NORTH = 3'b000,
    GATE_EAST  = 3'b001,
    GATE_SOUTH = 3'b010,
    GATE_WEST  = 3'b011,
    GATE_PE    = 3'b100
  } gate_t;

  // Packet framing tracker states
  typedef enum logic {
    FR_IDLE   = 1'b0,
    FR_IN_PKT = 1'b1
  } frame_state_t;

  function automatic flit_type_t flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_t'(flit[TYPE_HI:TYPE_LO]);
  endfunction

  // Saturating increment for 8-bit event counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/noc_fifo_mem.sv
// DEPTH x FLIT_W register array with one write port and a registered read
// port. The read register doubles as the buffer's output flit register; the
// load path lets the top steer the write data straight into it (bypass).
module noc_fifo_mem
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rd_addr,
  input  logic              load_en,
  output logic [FLIT_W-1:0] rd_data
);

  logic [FLIT_W-1:0] mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Storage entry gi: captures write data when addressed
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == PTR_W'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Read register: load (bypass) and read never coincide; otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (load_en) begin
      rd_data <= wr_data;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/noc_input_buffer.sv
// Router input-port FIFO ahead of route computation. Valid/ready on the
// input, registered enable + flit on the output, frozen while stall is high.
// Tracks header/body/tail framing and counts framing errors (saturating).
// Build option NOC_IBUF_BYPASS_EN: an empty, unstalled buffer forwards a
// pushed flit to the output on the push edge without touching memory.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  input  logic              stall,
  output logic              out_enable,
  output logic [FLIT_W-1:0] out_flit,
  output logic [PTR_W:0]    count,
  output logic [7:0]        frame_err_cnt
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             out_enable_reg;
  frame_state_t     state_reg;
  logic [7:0]       err_cnt_reg;

  logic push;
  logic pop;
  logic bypass;
  logic store;

  // Ready comes only from registered occupancy, never from a same-cycle pop
  assign in_ready = (count_reg != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = (count_reg != '0) & ~stall;

`ifdef NOC_IBUF_BYPASS_EN
  assign bypass = push & (count_reg == '0) & ~stall;
`else
  assign bypass = 1'b0;
`endif

  assign store = push & ~bypass;

  noc_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store),
    .wr_addr (wr_ptr_reg),
    .wr_data (in_flit),
    .rd_en   (pop),
    .rd_addr (rd_ptr_reg),
    .load_en (bypass),
    .rd_data (out_flit)
  );

  // Pointers wrap naturally (DEPTH is a power of two); occupancy follows store/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (store) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({store, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Output strobe: one pulse per flit delivered to the route stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_enable_reg <= 1'b0;
    end else begin
      out_enable_reg <= pop | bypass;
    end
  end

  // Framing tracker, advanced on every accepted flit; errors never drop data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= FR_IDLE;
      err_cnt_reg <= 8'd0;
    end else if (push) begin
      case (state_reg)
        FR_IDLE: begin
          case (flit_type(in_flit))
            FT_HEADER: state_reg <= FR_IN_PKT;
            FT_HSHAKE: state_reg <= FR_IDLE;
            default:   err_cnt_reg <= sat_inc8(err_cnt_reg);
          endcase
        end
        FR_IN_PKT: begin
          case (flit_type(in_flit))
            FT_BODY:   state_reg <= FR_IN_PKT;
            FT_TAIL:   state_reg <= FR_IDLE;
            FT_HEADER: begin
              state_reg   <= FR_IN_PKT;
              err_cnt_reg <= sat_inc8(err_cnt_reg);
            end
            default: begin
              state_reg   <= FR_IDLE;
              err_cnt_reg <= sat_inc8(err_cnt_reg);
            end
          endcase
        end
        default: state_reg <= FR_IDLE;
      endcase
    end
  end

  assign out_enable    = out_enable_reg;
  assign count         = count_reg;
  assign frame_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed self-checking bench for noc_input_buffer (DEPTH = 4).
// Expected latency/occupancy follow the NOC_IBUF_BYPASS_EN build option.
module tb_noc_input_buffer;

  localparam int DEPTH = 4;
`ifdef NOC_IBUF_BYPASS_EN
  localparam int LAT = 1;
  localparam int BYP = 1;
`else
  localparam int LAT = 2;
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_flit;
  logic        in_ready;
  logic        stall;
  logic        out_enable;
  logic [31:0] out_flit;
  logic [2:0]  count;
  logic [7:0]  frame_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  noc_input_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_flit       (in_flit),
    .in_ready      (in_ready),
    .stall         (stall),
    .out_enable    (out_enable),
    .out_flit      (out_flit),
    .count         (count),
    .frame_err_cnt (frame_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; stall = 1'b0;
    #2;
    n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b expected 0", out_enable); end
    n_cmp++; if (out_flit !== 32'h0) begin n_bad++; $display("FAIL reset_flit: got %h expected 00000000", out_flit); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (frame_err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err: got %0d expected 0", frame_err_cnt); end
    tick; tick;
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    $display("reset: done");
  endtask

  task automatic test_packet;
    logic [31:0] f [3];
    int idx;
    f = '{32'h8140_0000, 32'h0000_0001, 32'h4000_0002};
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 3);
      in_flit  = (k < 3) ? f[k % 3] : 32'h0;
      tick;
      idx = k - (LAT - 1);
      n_cmp++;
      if (idx >= 0 && idx < 3) begin
        if (out_enable !== 1'b1 || out_flit !== f[idx]) begin
          n_bad++; $display("FAIL packet_out[%0d]: got oe=%b %h expected oe=1 %h", k, out_enable, out_flit, f[idx]);
        end
      end else if (out_enable !== 1'b0) begin
        n_bad++; $display("FAIL packet_idle[%0d]: got oe=%b expected oe=0", k, out_enable);
      end
      $display("packet cycle %0d: oe=%b flit=%h count=%0d", k, out_enable, out_flit, count);
    end
    in_valid = 1'b0;
    n_cmp++; if (frame_err_cnt !== 8'd0) begin n_bad++; $display("FAIL packet_err: got %0d expected 0", frame_err_cnt); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL packet_count: got %0d expected 0", count); end
  endtask

  task automatic test_full_stall;
    logic [31:0] d [5];
    for (int k = 0; k < 5; k++) d[k] = 32'hC000_0010 + 32'(k);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_flit  = d[k];
      n_cmp++;
      if (in_ready !== (k < 4)) begin
        n_bad++; $display("FAIL full_ready[%0d]: got %b expected %b", k, in_ready, (k < 4));
      end
      tick;
      $display("stalled push %0d: ready_before=%b count=%0d", k, (k < 4), count);
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d expected 4", count); end
    n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("FAIL full_oe: got %b expected 0", out_enable); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_hold: got %b expected 0", in_ready); end
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_cmp++;
      if (k < 4) begin
        if (out_enable !== 1'b1 || out_flit !== d[k]) begin
          n_bad++; $display("FAIL drain[%0d]: got oe=%b %h expected oe=1 %h", k, out_enable, out_flit, d[k]);
        end
      end else if (out_enable !== 1'b0) begin
        n_bad++; $display("FAIL drain_extra: got oe=%b %h expected oe=0", out_enable, out_flit);
      end
      $display("drain %0d: oe=%b flit=%h count=%0d", k, out_enable, out_flit, count);
    end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d [20];
    int idx;
    for (int k = 0; k < 20; k++) d[k] = 32'hC000_0100 + 32'(k);
    for (int k = 0; k < 22; k++) begin
      in_valid = (k < 20);
      in_flit  = (k < 20) ? d[k % 20] : 32'h0;
      tick;
      idx = k - (LAT - 1);
      n_cmp++;
      if (idx >= 0 && idx < 20) begin
        if (out_enable !== 1'b1 || out_flit !== d[idx]) begin
          n_bad++; $display("FAIL stream_out[%0d]: got oe=%b %h expected oe=1 %h", k, out_enable, out_flit, d[idx]);
        end
      end else if (out_enable !== 1'b0) begin
        n_bad++; $display("FAIL stream_idle[%0d]: got oe=%b expected 0", k, out_enable);
      end
      if (k < 20) begin
        n_cmp++;
        if (count !== 3'(1 - BYP)) begin
          n_bad++; $display("FAIL stream_count[%0d]: got %0d expected %0d", k, count, 1 - BYP);
        end
      end
      $display("stream cycle %0d: oe=%b flit=%h count=%0d", k, out_enable, out_flit, count);
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL stream_end_count: got %0d expected 0", count); end
  endtask

  task automatic test_framing;
    logic [31:0] f [4];
    int idx;
    f = '{32'h0000_0005, 32'h8000_0006, 32'h8000_0007, 32'h4000_0008};
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 4);
      in_flit  = (k < 4) ? f[k % 4] : 32'h0;
      tick;
      if (k == 0) begin
        n_cmp++;
        if (frame_err_cnt !== 8'd1) begin n_bad++; $display("FAIL frame_err_body: got %0d expected 1", frame_err_cnt); end
      end
      idx = k - (LAT - 1);
      n_cmp++;
      if (idx >= 0 && idx < 4) begin
        if (out_enable !== 1'b1 || out_flit !== f[idx]) begin
          n_bad++; $display("FAIL frame_out[%0d]: got oe=%b %h expected oe=1 %h", k, out_enable, out_flit, f[idx]);
        end
      end else if (out_enable !== 1'b0) begin
        n_bad++; $display("FAIL frame_idle[%0d]: got oe=%b expected 0", k, out_enable);
      end
      $display("framing cycle %0d: oe=%b flit=%h err=%0d", k, out_enable, out_flit, frame_err_cnt);
    end
    in_valid = 1'b0;
    n_cmp++; if (frame_err_cnt !== 8'd2) begin n_bad++; $display("FAIL frame_err_total: got %0d expected 2", frame_err_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q [4];
    int idx;
    q = '{32'h8000_0020, 32'h0000_0021, 32'h0000_0022, 32'h0000_0023};
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_flit  = q[k];
      tick;
    end
    in_valid = 1'b0;
    stall = 1'b0;
    tick;
    n_cmp++; if (out_enable !== 1'b1 || out_flit !== q[0]) begin n_bad++; $display("FAIL prerst_out: got oe=%b %h expected oe=1 %h", out_enable, out_flit, q[0]); end
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL prerst_count: got %0d expected 3", count); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("FAIL midrst_oe: got %b expected 0", out_enable); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL midrst_count: got %0d expected 0", count); end
    n_cmp++; if (out_flit !== 32'h0) begin n_bad++; $display("FAIL midrst_flit: got %h expected 00000000", out_flit); end
    n_cmp++; if (frame_err_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_err: got %0d expected 0", frame_err_cnt); end
    $display("mid-reset: oe=%b count=%0d flit=%h", out_enable, count, out_flit);
    tick;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = (k == 0);
      in_flit  = (k == 0) ? 32'h8000_0030 : 32'h0;
      tick;
      idx = k - (LAT - 1);
      n_cmp++;
      if (idx == 0) begin
        if (out_enable !== 1'b1 || out_flit !== 32'h8000_0030) begin
          n_bad++; $display("FAIL postrst_out[%0d]: got oe=%b %h expected oe=1 80000030", k, out_enable, out_flit);
        end
      end else if (out_enable !== 1'b0) begin
        n_bad++; $display("FAIL postrst_idle[%0d]: got oe=%b expected 0", k, out_enable);
      end
      $display("post-reset cycle %0d: oe=%b flit=%h count=%0d", k, out_enable, out_flit, count);
    end
    in_valid = 1'b0;
    n_cmp++; if (frame_err_cnt !== 8'd0) begin n_bad++; $display("FAIL postrst_err: got %0d expected 0", frame_err_cnt); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL postrst_count: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset;
    test_packet;
    test_full_stall;
    test_back_to_back;
    test_framing;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
